// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter sharing one SPI memory request port between N requesters.
// One transaction in flight at a time: IDLE -> ISSUE -> RESP -> IDLE.
module spi_mem_arbiter #(
  parameter int N  = 2,
  parameter int AW = 24,
  parameter int DW = 32,
  parameter int GW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_wdata,
  input  logic [N-1:0]    req_we,
  input  logic [N-1:0]    req_sel,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  output logic [DW-1:0]   req_rdata,
  output logic [AW-1:0]   spi_addr,
  output logic [DW-1:0]   spi_wdata,
  output logic            spi_we,
  output logic            spi_mem_select,
  output logic            spi_valid,
  input  logic            spi_ready,
  input  logic [DW-1:0]   spi_rdata,
  output logic            busy,
  output logic [GW-1:0]   grant
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] last_q, last_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [AW-1:0] spi_addr_q, spi_addr_d;
  logic [DW-1:0] spi_wdata_q, spi_wdata_d;
  logic          spi_we_q, spi_we_d;
  logic          spi_sel_q, spi_sel_d;
  logic          spi_valid_q, spi_valid_d;
  logic [N-1:0]  req_ready_q, req_ready_d;
  logic [DW-1:0] req_rdata_q, req_rdata_d;
  logic          busy_q, busy_d;

  logic [GW-1:0] win_idx, cand;
  logic          win_found;

  logic [AW-1:0] addr_a  [N];
  logic [DW-1:0] wdata_a [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign addr_a[gi]  = req_addr[gi*AW +: AW];
      assign wdata_a[gi] = req_wdata[gi*DW +: DW];
    end
  endgenerate

  // Scan from farthest to nearest so the nearest valid index after last_q wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = N; k >= 1; k--) begin
      cand = GW'((int'(last_q) + k) % N);
      if (req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    spi_addr_d  = spi_addr_q;
    spi_wdata_d = spi_wdata_q;
    spi_we_d    = spi_we_q;
    spi_sel_d   = spi_sel_q;
    spi_valid_d = spi_valid_q;
    req_ready_d = '0;
    req_rdata_d = req_rdata_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d     = win_idx;
          last_d      = win_idx;
          spi_addr_d  = addr_a[win_idx];
          spi_wdata_d = wdata_a[win_idx];
          spi_we_d    = req_we[win_idx];
          spi_sel_d   = req_sel[win_idx];
          spi_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (spi_ready) begin
          spi_valid_d          = 1'b0;
          req_rdata_d          = spi_rdata;
          req_ready_d[grant_q] = 1'b1;
          state_d              = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= GW'(N - 1);
      grant_q     <= '0;
      spi_addr_q  <= '0;
      spi_wdata_q <= '0;
      spi_we_q    <= 1'b0;
      spi_sel_q   <= 1'b0;
      spi_valid_q <= 1'b0;
      req_ready_q <= '0;
      req_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      spi_addr_q  <= spi_addr_d;
      spi_wdata_q <= spi_wdata_d;
      spi_we_q    <= spi_we_d;
      spi_sel_q   <= spi_sel_d;
      spi_valid_q <= spi_valid_d;
      req_ready_q <= req_ready_d;
      req_rdata_q <= req_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign req_rdata      = req_rdata_q;
  assign spi_addr       = spi_addr_q;
  assign spi_wdata      = spi_wdata_q;
  assign spi_we         = spi_we_q;
  assign spi_mem_select = spi_sel_q;
  assign spi_valid      = spi_valid_q;
  assign busy           = busy_q;
  assign grant          = grant_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Self-checking bench for spi_mem_arbiter (N=4): directed scenarios plus a
// randomized run checked against a round-robin reference model.
module tb_spi_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_we = '0;
  logic [N-1:0]    req_sel = '0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   req_rdata;
  logic [AW-1:0]   spi_addr;
  logic [DW-1:0]   spi_wdata;
  logic            spi_we;
  logic            spi_mem_select;
  logic            spi_valid;
  logic            spi_ready = 1'b0;
  logic [DW-1:0]   spi_rdata = '0;
  logic            busy;
  logic [GW-1:0]   grant;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: last served requester and last delivered read data.
  int          m_last;
  logic [31:0] m_rdata;

  spi_mem_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we),
    .req_sel(req_sel), .req_valid(req_valid), .req_ready(req_ready),
    .req_rdata(req_rdata), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_we(spi_we), .spi_mem_select(spi_mem_select), .spi_valid(spi_valid),
    .spi_ready(spi_ready), .spi_rdata(spi_rdata), .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [23:0] a, input logic [31:0] d,
                         input logic we, input logic sel);
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_we[i]             = we;
    req_sel[i]            = sel;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_last  = N - 1;
    m_rdata = '0;
  endtask

  // Behaves as the SPI controller: waits for spi_valid, holds lat cycles,
  // answers with rd, and returns what was observed (no judging here).
  task automatic spi_serve(input int lat, input logic [31:0] rd,
                           output int waited, output bit timeout, output bit stable,
                           output logic [1:0] g, output logic [23:0] a,
                           output logic [31:0] wd, output logic we, output logic sel,
                           output logic [3:0] rdy, output logic [31:0] rdat,
                           output logic sv_after);
    waited = 0; timeout = 1'b0; stable = 1'b1;
    g = '0; a = '0; wd = '0; we = 1'b0; sel = 1'b0; rdy = '0; rdat = '0; sv_after = 1'b0;
    while (spi_valid !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    if (spi_valid !== 1'b1) begin
      timeout = 1'b1;
      return;
    end
    g = grant; a = spi_addr; wd = spi_wdata; we = spi_we; sel = spi_mem_select;
    repeat (lat) begin
      tick();
      if (spi_valid !== 1'b1 || spi_addr !== a || spi_wdata !== wd ||
          spi_we !== we || spi_mem_select !== sel || grant !== g)
        stable = 1'b0;
    end
    spi_ready = 1'b1;
    spi_rdata = rd;
    tick();
    spi_ready = 1'b0;
    spi_rdata = $urandom;
    rdy = req_ready; rdat = req_rdata; sv_after = spi_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({spi_valid, spi_we, spi_mem_select, busy} !== 4'b0000)
      $display("FAIL reset_flags got %b want 0000", {spi_valid, spi_we, spi_mem_select, busy});
    else n_pass++;
    n_checks++;
    if (spi_addr !== '0 || spi_wdata !== '0)
      $display("FAIL reset_spi_data got addr=%h wdata=%h want 0", spi_addr, spi_wdata);
    else n_pass++;
    n_checks++;
    if (req_ready !== '0 || req_rdata !== '0 || grant !== '0)
      $display("FAIL reset_req got ready=%b rdata=%h grant=%0d want 0", req_ready, req_rdata, grant);
    else n_pass++;
    rst = 1'b0;
    m_last  = N - 1;
    m_rdata = '0;
  endtask

  task automatic test_single_read();
    int w; bit to, st; logic [1:0] g; logic [23:0] a; logic [31:0] wd, rdat;
    logic we, sel, sv; logic [3:0] rdy;
    set_req(0, 24'h012340, 32'h0, 1'b0, 1'b0);
    req_valid = 4'b0001;
    spi_serve(5, 32'hDEADBEEF, w, to, st, g, a, wd, we, sel, rdy, rdat, sv);
    n_checks++;
    if (to || w != 1) $display("FAIL read_latency got timeout=%0d wait=%0d want 0/1", to, w);
    else n_pass++;
    n_checks++;
    if (g !== 2'd0 || a !== 24'h012340 || we !== 1'b0 || sel !== 1'b0)
      $display("FAIL read_issue got g=%0d addr=%h we=%b sel=%b want 0/012340/0/0", g, a, we, sel);
    else n_pass++;
    n_checks++;
    if (!st) $display("FAIL read_stable got unstable want stable");
    else n_pass++;
    n_checks++;
    if (rdy !== 4'b0001 || rdat !== 32'hDEADBEEF || sv !== 1'b0)
      $display("FAIL read_resp got rdy=%b rdata=%h spi_valid=%b want 0001/deadbeef/0", rdy, rdat, sv);
    else n_pass++;
    req_valid = '0;
    tick();
    n_checks++;
    if (req_ready !== '0 || busy !== 1'b0)
      $display("FAIL read_pulse_end got rdy=%b busy=%b want 0000/0", req_ready, busy);
    else n_pass++;
    m_last = 0; m_rdata = 32'hDEADBEEF;
  endtask

  task automatic test_write();
    int w; bit to, st; logic [1:0] g; logic [23:0] a; logic [31:0] wd, rdat, rd;
    logic we, sel, sv; logic [3:0] rdy;
    rd = $urandom;
    set_req(1, 24'h000100, 32'hA5A5_5A5A, 1'b1, 1'b1);
    req_valid = 4'b0010;
    spi_serve(3, rd, w, to, st, g, a, wd, we, sel, rdy, rdat, sv);
    n_checks++;
    if (to || g !== 2'd1 || a !== 24'h000100 || wd !== 32'hA5A55A5A || we !== 1'b1 || sel !== 1'b1)
      $display("FAIL write_issue got to=%0d g=%0d addr=%h wd=%h we=%b sel=%b want 0/1/000100/a5a55a5a/1/1",
               to, g, a, wd, we, sel);
    else n_pass++;
    n_checks++;
    if (!st) $display("FAIL write_stable got unstable want stable");
    else n_pass++;
    n_checks++;
    if (rdy !== 4'b0010 || rdat !== rd)
      $display("FAIL write_resp got rdy=%b rdata=%h want 0010/%h", rdy, rdat, rd);
    else n_pass++;
    req_valid = '0;
    tick();
    m_last = 1; m_rdata = rd;
  endtask

  task automatic test_simultaneous();
    int w; bit to, st; logic [1:0] g; logic [23:0] a; logic [31:0] wd, rdat, rd;
    logic we, sel, sv; logic [3:0] rdy, prev;
    int exp_g [4] = '{0, 1, 0, 1};
    do_reset();
    set_req(0, 24'h000010, 32'h1, 1'b0, 1'b0);
    set_req(1, 24'h000020, 32'h2, 1'b0, 1'b1);
    req_valid = 4'b0011;
    prev = '0;
    for (int i = 0; i < 4; i++) begin
      rd = $urandom;
      spi_serve(0, rd, w, to, st, g, a, wd, we, sel, rdy, rdat, sv);
      n_checks++;
      if (to || int'(g) != exp_g[i] || rdy !== (4'b0001 << exp_g[i]))
        $display("FAIL simul_grant[%0d] got to=%0d g=%0d rdy=%b want g=%0d", i, to, g, rdy, exp_g[i]);
      else n_pass++;
      n_checks++;
      if (w != ((i == 0) ? 1 : 2))
        $display("FAIL simul_spacing[%0d] got wait=%0d want %0d", i, w, (i == 0) ? 1 : 2);
      else n_pass++;
      n_checks++;
      if (rdy === prev) $display("FAIL simul_repeat[%0d] got rdy=%b twice want alternation", i, rdy);
      else n_pass++;
      prev = rdy;
      m_last = exp_g[i]; m_rdata = rd;
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_fairness();
    int w; bit to, st; logic [1:0] g; logic [23:0] a; logic [31:0] wd, rdat, rd;
    logic we, sel, sv; logic [3:0] rdy;
    int exp_g [4] = '{0, 2, 3, 0};
    do_reset();
    set_req(2, 24'h000300, 32'h3, 1'b0, 1'b0);
    set_req(3, 24'h000400, 32'h4, 1'b1, 1'b0);
    req_valid = 4'b1001;
    tick();
    req_valid[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd = $urandom;
      spi_serve(i % 3, rd, w, to, st, g, a, wd, we, sel, rdy, rdat, sv);
      n_checks++;
      if (to || int'(g) != exp_g[i] || rdy !== (4'b0001 << exp_g[i]))
        $display("FAIL fair_grant[%0d] got to=%0d g=%0d rdy=%b want g=%0d", i, to, g, rdy, exp_g[i]);
      else n_pass++;
      if (exp_g[i] == 2) req_valid[2] = 1'b0;
      m_last = exp_g[i]; m_rdata = rd;
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    int w; bit to, st; logic [1:0] g; logic [23:0] a; logic [31:0] wd, rdat, rd;
    logic we, sel, sv; logic [3:0] rdy;
    req_valid = 4'b0011;
    tick();
    n_checks++;
    if (spi_valid !== 1'b1 || grant !== 2'd1)
      $display("FAIL rstmid_pre got spi_valid=%b grant=%0d want 1/1", spi_valid, grant);
    else n_pass++;
    do_reset();
    n_checks++;
    if (spi_valid !== 1'b0 || busy !== 1'b0 || grant !== 2'd0 || req_ready !== '0 || spi_addr !== '0)
      $display("FAIL rstmid_post got spi_valid=%b busy=%b grant=%0d rdy=%b addr=%h want 0",
               spi_valid, busy, grant, req_ready, spi_addr);
    else n_pass++;
    rd = $urandom;
    spi_serve(1, rd, w, to, st, g, a, wd, we, sel, rdy, rdat, sv);
    n_checks++;
    if (to || g !== 2'd0 || rdy !== 4'b0001 || rdat !== rd)
      $display("FAIL rstmid_first got to=%0d g=%0d rdy=%b rdata=%h want 0/0/0001/%h", to, g, rdy, rdat, rd);
    else n_pass++;
    req_valid = '0;
    tick();
    m_last = 0; m_rdata = rd;
  endtask

  task automatic test_spurious_ready();
    tick();
    spi_ready = 1'b1;
    spi_rdata = 32'h1357_2468;
    tick();
    spi_ready = 1'b0;
    n_checks++;
    if (req_ready !== '0 || busy !== 1'b0 || spi_valid !== 1'b0 || req_rdata !== m_rdata)
      $display("FAIL spurious got rdy=%b busy=%b spi_valid=%b rdata=%h want 0000/0/0/%h",
               req_ready, busy, spi_valid, req_rdata, m_rdata);
    else n_pass++;
    tick();
    n_checks++;
    if (req_ready !== '0 || busy !== 1'b0)
      $display("FAIL spurious_after got rdy=%b busy=%b want 0000/0", req_ready, busy);
    else n_pass++;
  endtask

  task automatic test_random();
    int w, win, lat; bit to, st; logic [1:0] g; logic [23:0] a; logic [31:0] wd, rdat, rd;
    logic we, sel, sv; logic [3:0] rdy, pend;
    logic [23:0] m_addr [4]; logic [31:0] m_wd [4]; logic m_we [4]; logic m_sel [4];
    pend = '0;
    for (int i = 0; i < 4; i++) begin
      m_addr[i] = '0; m_wd[i] = '0; m_we[i] = 1'b0; m_sel[i] = 1'b0;
    end
    for (int t = 0; t < 40; t++) begin
      while (pend == 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          if (!pend[i] && $urandom_range(0, 1) == 1) begin
            pend[i]   = 1'b1;
            m_addr[i] = 24'($urandom);
            m_wd[i]   = $urandom;
            m_we[i]   = 1'($urandom);
            m_sel[i]  = 1'($urandom);
            set_req(i, m_addr[i], m_wd[i], m_we[i], m_sel[i]);
          end
        end
      end
      req_valid = pend;
      win = -1;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (win < 0 && pend[idx]) win = idx;
      end
      rd  = $urandom;
      lat = $urandom_range(0, 4);
      spi_serve(lat, rd, w, to, st, g, a, wd, we, sel, rdy, rdat, sv);
      n_checks++;
      if (to || int'(g) != win)
        $display("FAIL rand_grant[%0d] got to=%0d g=%0d want %0d", t, to, g, win);
      else n_pass++;
      n_checks++;
      if (a !== m_addr[win] || wd !== m_wd[win] || we !== m_we[win] || sel !== m_sel[win])
        $display("FAIL rand_fields[%0d] got %h/%h/%b/%b want %h/%h/%b/%b", t, a, wd, we, sel,
                 m_addr[win], m_wd[win], m_we[win], m_sel[win]);
      else n_pass++;
      n_checks++;
      if (!st || rdy !== (4'b0001 << win) || rdat !== rd || sv !== 1'b0)
        $display("FAIL rand_resp[%0d] got stable=%0d rdy=%b rdata=%h spi_valid=%b want 1/%b/%h/0",
                 t, st, rdy, rdat, sv, 4'b0001 << win, rd);
      else n_pass++;
      pend[win] = 1'b0;
      req_valid = pend;
      m_last  = win;
      m_rdata = rd;
      if (to) pend = '0;
    end
    req_valid = '0;
    tick();
    tick();
  endtask

  initial begin
    m_last  = N - 1;
    m_rdata = '0;
    test_reset();
    test_single_read();
    test_write();
    test_simultaneous();
    test_fairness();
    test_reset_mid();
    test_spurious_ready();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_mem_arbiter.md
# spi_mem_arbiter

Round-robin arbiter that shares the single SPI memory request port (flash / PSRAM behind the SPI controller) between N requesters. Typical requesters are the CPU bus bridge and the ADPCM sample fetcher. The block sits between those requesters and the SPI memory controller. It registers one request at a time, holds it stable on the SPI port until the controller accepts it, then returns the read data and a one-cycle ready pulse to the winning requester.

## Interface

**Parameters**
- `N`, default 2: number of requesters, 2..8.
- `AW`, default 24: SPI byte address width.
- `DW`, default 32: data width.
- `GW`, default `$clog2(N)`: grant index width. This value is derived, not set.

**Ports**
- `clk` in, 1: system clock. This is the only clock.
- `rst` in, 1: reset, synchronous, active-high.
- `req_addr` in, N*AW: address for each requester; requester i uses bits `[i*AW +: AW]`.
- `req_wdata` in, N*DW: write data for each requester.
- `req_we` in, N: write enable for each requester.
- `req_sel` in, N: memory select for each requester (0 = flash, 1 = PSRAM).
- `req_valid` in, N: request strobe for each requester. It is held high until that requester's `req_ready` pulse.
- `req_ready` out, N: one-cycle completion pulse for each requester. At most one bit is high in any cycle.
- `req_rdata` out, DW: read data shared by all requesters. It is valid in the cycle where any `req_ready` bit is high.
- `spi_addr` out, AW: registered address to the SPI controller.
- `spi_wdata` out, DW: registered write data.
- `spi_we` out, 1: registered write enable.
- `spi_mem_select` out, 1: registered memory select.
- `spi_valid` out, 1: request strobe to the SPI controller.
- `spi_ready` in, 1: completion strobe from the SPI controller.
- `spi_rdata` in, DW: read data from the SPI controller.
- `busy` out, 1: high in every state other than IDLE.
- `grant` out, GW: index of the requester currently or most recently served.

## Operation

**State machine:** IDLE → ISSUE → RESP → IDLE.
- **IDLE**
  - If any `req_valid` bit is high, select the winner by round-robin. The search starts at index `(last+1) mod N` and takes the first valid bit found.
  - On selection: register `grant`, copy the winner's addr, wdata, we and sel into the `spi_*` registers, set `spi_valid`, update `last` to the winner, and go to ISSUE.
  - If no bit is valid, stay in IDLE.
- **ISSUE**
  - Hold `spi_valid` = 1 and keep all `spi_*` outputs stable.
  - On `spi_ready` = 1: clear `spi_valid`, capture `spi_rdata` into `req_rdata`, and go to RESP.
- **RESP**
  - Drive `req_ready[grant]` = 1 for exactly this cycle, then go to IDLE.

**Rules**
- `last` resets to N-1, so requester 0 wins the first contention.
- After a completed grant, the granted requester has the lowest priority. With all N requesters continuously requesting, each requester is served once every N transactions.
- `spi_rdata` is captured on writes as well. Requesters ignore it for writes.
- `spi_ready` is ignored in IDLE and RESP.
- The `req_*` inputs are sampled only in IDLE. Changes in ISSUE or RESP have no effect on the transaction in flight.
- If a requester drops `req_valid` before completion (a protocol violation), the transaction still completes and the `req_ready` pulse is still issued.
- A requester that re-asserts `req_valid` in the cycle after its `req_ready` pulse competes normally in IDLE.

**Reset**
- At the first clock edge with `rst` high: state becomes IDLE.
- `spi_valid`, `spi_we`, `spi_mem_select`, `spi_addr`, `spi_wdata`, `req_ready`, `req_rdata`, `busy` and `grant` all become 0. `last` becomes N-1.
- This applies mid-transaction. The SPI controller shares `rst` and aborts with it, so no completion pulse is generated.

## Timing

- **Cycle C:** `req_valid` is sampled high in IDLE.
- **Cycle C+1:** `spi_valid` = 1 and `busy` = 1.
- **Completion:** if `spi_ready` arrives in cycle K ≥ C+1, then in cycle K+1 `req_ready` = 1, `req_rdata` = `spi_rdata`@K, and `spi_valid` = 0.
- **Minimum latency:** 2 cycles from the sampled `req_valid` to `req_ready`, reached when `spi_ready` arrives in cycle C+1.
- **Back to IDLE:** the block is in IDLE at cycle K+2. The next `spi_valid` is at K+3, giving a minimum of 3 cycles per transaction.
- **SPI controller contract:** `spi_valid` never drops without a preceding `spi_ready`. The `spi_*` outputs never change while `spi_valid` = 1.
- **Critical path:** round-robin selection plus a mux of width N×(AW+DW+2). All outputs are registered.

## Test plan

- **Single read:** req0 valid, addr 0x012340, sel=0; `spi_ready` 5 cycles after `spi_valid` with rdata 0xDEADBEEF → `spi_addr` = 0x012340, `spi_we` = 0; `req_ready` = 2'b01 for exactly one cycle; `req_rdata` = 0xDEADBEEF.
- **Write pass-through:** req1 write, addr 0x000100, wdata 0xA5A5_5A5A, sel=1 → `spi_we` = 1, `spi_mem_select` = 1, `spi_wdata` = 0xA5A55A5A held stable until `spi_ready`; `req_ready` = 2'b10.
- **Simultaneous requests:** req0 and req1 both continuously valid after reset, `spi_ready` immediate → grants in order 0,1,0,1; a new `spi_valid` every 3 cycles; `req_ready` never targets a requester twice in a row.
- **Fairness, N=4:** requesters 0 and 3 continuously valid; requester 2 asserts valid while requester 0 is in ISSUE → next grant goes to 2, then 3, then 0.
- **Reset mid-transaction:** `rst` pulsed during ISSUE → next cycle `spi_valid` = 0, `busy` = 0, `grant` = 0, no `req_ready`; after reset, with req0 and req1 valid, requester 0 wins.
- **Spurious ready:** `spi_ready` pulsed in IDLE with no requests → no state change, `req_ready` = 0, `req_rdata` unchanged.
